mem_access_sequencer: RTL
=========================

# mem_access_sequencer

Multicycle memory access sequencer for the 24-bit multicycle computer. It accepts one read or write request from the control unit and drives a single-port memory with a variable-latency ready handshake. On a successful read it returns the memory word together with a one-cycle load-enable strobe that drives the data register's `enable` and `data_in`. It sits between the memory and the data register, directly upstream of the data register.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, memory word-address width.
- `DATA_WIDTH`, 24, data word width; must match the data register.
- `TIMEOUT`, 15, maximum number of ACCESS cycles before the access aborts. Range 1–255.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_WIDTH  word address; sampled with `req`.
- `wdata`  in  DATA_WIDTH  write data; sampled with `req`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse for both reads and writes.
- `err`  out  1  one-cycle pulse, coincident with `done`, when the access timed out.
- `rdata_out`  out  DATA_WIDTH  last successfully read word; connects to the data register `data_in`.
- `dr_enable`  out  1  one-cycle strobe; connects to the data register `enable`.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_re`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_ready`  in  1  memory completion; the access completes in the cycle it is sampled high.
- `mem_rdata`  in  DATA_WIDTH  read data; valid when `mem_ready` is high.

## Operation
- All outputs are registered.
- Reset values: state = IDLE; all outputs = 0, including `rdata_out`, `mem_addr` and `mem_wdata`; wait counter = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE
  - On `req` = 1: latch `addr` into `mem_addr`, `wdata` into `mem_wdata`, and `we`.
  - Assert `mem_we` if the request is a write, `mem_re` if it is a read.
  - Clear the wait counter and go to ACCESS.
- ACCESS: hold the strobes, `mem_addr` and `mem_wdata` stable.
  - `mem_ready` = 1:
    - Drop both strobes.
    - On a read, load `mem_rdata` into `rdata_out`.
    - Go to DONE with a success flag.
  - `mem_ready` = 0 and counter = TIMEOUT−1: drop both strobes and go to DONE with a timeout flag.
  - Otherwise: increment the counter.
- DONE, one cycle:
  - `done` = 1 in all cases.
  - `err` = 1 if the timeout flag is set.
  - `dr_enable` = 1 only for a successful read.
  - Return to IDLE.
- `req` in ACCESS or DONE is ignored, not queued. The control unit must wait for `done`.
- `req` held high in IDLE across consecutive accesses starts a new access on the cycle after DONE.
- `rdata_out` changes only on a successful read. Writes and timed-out reads leave it unchanged.
- `mem_re` and `mem_we` are never high simultaneously.
- The 8-bit wait counter saturates at TIMEOUT−1. There is no wrap-around.

## Timing
- Cycle numbering: cycle 0 = `req` sampled in IDLE. Cycle 1 = first ACCESS cycle, with strobes high.
- Best case: `mem_ready` high in cycle 1 gives `done` in cycle 2.
  - The data register captures `rdata_out` at the end of cycle 2.
  - Its output is valid in cycle 3.
- N wait cycles (`mem_ready` first high in cycle 1+N): `done` in cycle 2+N.
- Timeout: strobes are high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); `done` and `err` are high in cycle TIMEOUT+1.
- `mem_ready` high in the same cycle the counter reaches TIMEOUT−1: success takes priority and `err` stays 0.
- `mem_ready` outside ACCESS is ignored.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- Reset asserted mid-operation: on the next edge the FSM returns to IDLE, all outputs are 0, and the access is abandoned with no `done`.
- Reset has priority over `req`.

## Configuration
- `MEM_TIMEOUT_EN` defined: the wait counter and timeout path are compiled in, as described above.
- `MEM_TIMEOUT_EN` undefined:
  - No counter is built.
  - ACCESS waits indefinitely for `mem_ready`.
  - `err` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Reset: hold `reset` 2 cycles with `req` = 1 → all outputs 0, `busy` = 0, no strobes.
- Zero-wait read: `addr` = 12'h0A5, `we` = 0, `mem_ready` high in cycle 1 with `mem_rdata` = 24'hA5A5A5 → `mem_re` high in cycle 1 only; `done` and `dr_enable` high in cycle 2; `rdata_out` = 24'hA5A5A5.
- 3-wait write: `addr` = 12'h010, `wdata` = 24'h123456, `mem_ready` high in cycle 4 → `mem_we` high in cycles 1–4 with `mem_wdata` = 24'h123456; `done` in cycle 5; `dr_enable` = 0; `rdata_out` unchanged.
- Timeout (`MEM_TIMEOUT_EN`, TIMEOUT = 15): read with `mem_ready` held 0 → `mem_re` high in cycles 1–15; `done` and `err` high in cycle 16; `dr_enable` = 0; `rdata_out` keeps its prior value.
- Request while busy: second `req` with `addr` = 12'hFFF in cycle 2 of a pending read → ignored; `mem_addr` unchanged; exactly one `done`.
- Reset mid-wait: assert `reset` in cycle 3 of a waiting read → cycle 4 has `busy` = 0, `mem_re` = 0, and no `done`; a subsequent read completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - multicycle memory access sequencer for the 24-bit multicycle computer
//
// Accepts one read/write request from the control unit, drives a single-port
// memory with a variable-latency ready handshake, and hands a successfully read
// word to the data register with a one-cycle load strobe.
//
// Optional feature macro: MEM_TIMEOUT_EN (wait counter + timeout abort path).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, we, addr, wdata  request from the control unit (sampled in IDLE only)
//   busy, done, err       status: busy outside IDLE, completion pulse, timeout pulse
//   rdata_out, dr_enable  data register data_in / enable
//   mem_addr, mem_wdata   memory address / write data
//   mem_re, mem_we        memory read / write strobes
//   mem_ready, mem_rdata  memory completion handshake and read data

module mem_access_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  dr_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic access_ok;
  logic access_timeout;

  logic                  busy_next, done_next, err_next, dr_enable_next;
  logic                  mem_re_next, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_next, rdata_next;

  assign access_ok = (state == S_ACCESS) && mem_ready;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  // Counter is zero on the first ACCESS cycle; holding at WAIT_LAST gives
  // saturation without wrap-around.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_IDLE) begin
      wait_cnt <= '0;
    end else if (state == S_ACCESS && wait_cnt != WAIT_LAST) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A ready in the last permitted cycle wins over the timeout.
  assign access_timeout = (state == S_ACCESS) && !mem_ready && (wait_cnt == WAIT_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign access_timeout = 1'b0;
`endif

  // State register; every output is a flop loaded from its *_next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dr_enable <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_out <= '0;
    end else begin
      state     <= state_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
      dr_enable <= dr_enable_next;
      mem_re    <= mem_re_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      rdata_out <= rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req) state_next = S_ACCESS;
      S_ACCESS: if (access_ok || access_timeout) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle early so the registered values line up
  // with the state they belong to (e.g. done is high while in DONE).
  always_comb begin
    busy_next      = (state_next != S_IDLE);
    done_next      = 1'b0;
    err_next       = 1'b0;
    dr_enable_next = 1'b0;
    mem_re_next    = mem_re;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    rdata_next     = rdata_out;
    case (state)
      S_IDLE: begin
        if (req) begin
          mem_addr_next  = addr;
          mem_wdata_next = wdata;
          mem_re_next    = !we;
          mem_we_next    = we;
        end
      end
      S_ACCESS: begin
        if (access_ok || access_timeout) begin
          mem_re_next = 1'b0;
          mem_we_next = 1'b0;
          done_next   = 1'b0 | 1'b1;
          err_next    = access_timeout;
          // mem_re still high here identifies the access as a read.
          if (access_ok && mem_re) begin
            rdata_next     = mem_rdata;
            dr_enable_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
